// File: rtl/cerebro_pkg.sv
// Shared definitions for the sample-array write path.
// Provides default geometry and the one-hot loader state encoding.
package cerebro_pkg;

    localparam int DATA_W_D = 12;
    localparam int DEPTH_D  = 64;
    localparam int IDX_W_D  = 6;

    typedef enum logic [5:0] {
        S_IDLE      = 6'b000001,
        S_WAIT_TRIG = 6'b000010,
        S_ACCEPT    = 6'b000100,
        S_HOLD      = 6'b001000,
        S_STROBE    = 6'b010000,
        S_DONE      = 6'b100000
    } state_t;

endpackage

// File: rtl/loader_decim.sv
// Decimation counter: counts handshakes modulo DECIM.
// Ports: clk, rst_n, clear (restart at 0), advance (one handshake),
//        keep (current handshake is the one to store).
module loader_decim #(
    parameter int DECIM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic advance,
    output logic keep
);

    logic [7:0] cnt;

    assign keep = (cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (advance) begin
            if (cnt == 8'(DECIM - 1))
                cnt <= 8'd0;
            else
                cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/array_loader.sv
// Write-side controller for the sample array: decimates a valid/ready
// sample stream and writes one frame of DEPTH samples per arm.
// Ports: clk, rst_n, arm, abort, trig, s_valid/s_data/s_ready (stream in),
//        put/p_index/p_val (array write port), busy, frame_done, frame_count.
module array_loader
    import cerebro_pkg::*;
#(
    parameter int DATA_W     = DATA_W_D,
    parameter int DEPTH      = DEPTH_D,
    parameter int IDX_W      = IDX_W_D,
    parameter int DECIM      = 1,
    parameter int TRIG_EN    = 1,
    parameter int CONTINUOUS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              put,
    output logic [IDX_W-1:0]  p_index,
    output logic [DATA_W-1:0] p_val,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_count
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
    localparam state_t ARM_ST = (TRIG_EN != 0) ? S_WAIT_TRIG : S_ACCEPT;

    state_t           state;
    state_t           next;
    logic [IDX_W-1:0] wr_ptr;
    logic             hs;
    logic             keep;
    logic             dec_clr;
    logic             dec_adv;
    logic             load;
    logic             wr_inc;
    logic             wr_clr;

    assign hs = s_valid && s_ready;

    loader_decim #(
        .DECIM(DECIM)
    ) u_decim (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (dec_clr),
        .advance(dec_adv),
        .keep   (keep)
    );

    always_comb begin
        next    = state;
        dec_clr = 1'b0;
        dec_adv = 1'b0;
        load    = 1'b0;
        wr_inc  = 1'b0;
        wr_clr  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (arm) begin
                    next    = ARM_ST;
                    dec_clr = 1'b1;
                    wr_clr  = 1'b1;
                end
            end
            S_WAIT_TRIG: begin
                // samples taken here are deliberately thrown away
                if (trig)
                    next = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (hs) begin
                    dec_adv = 1'b1;
                    if (keep) begin
                        load = 1'b1;
                        next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                next = S_STROBE;
            end
            S_STROBE: begin
                if (wr_ptr == LAST) begin
                    next   = S_DONE;
                    wr_clr = 1'b1;
                end else begin
                    next   = S_ACCEPT;
                    wr_inc = 1'b1;
                end
            end
            S_DONE: begin
                if (CONTINUOUS != 0) begin
                    next    = ARM_ST;
                    dec_clr = 1'b1;
                    wr_clr  = 1'b1;
                end else begin
                    next = S_IDLE;
                end
            end
            default: begin
                next = S_IDLE;
            end
        endcase
        if (abort) begin
            next = S_IDLE;
            load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            s_ready     <= 1'b0;
            put         <= 1'b0;
            p_index     <= '0;
            p_val       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state   <= next;
            s_ready <= (next == S_WAIT_TRIG) || (next == S_ACCEPT);
            busy    <= (next != S_IDLE);
            // put trails the STROBE state so an abort there cannot cut it short
            put        <= (state == S_STROBE);
            frame_done <= (state == S_DONE);
            if (state == S_DONE)
                frame_count <= frame_count + 8'd1;
            if (load) begin
                p_val   <= s_data;
                p_index <= wr_ptr;
            end
            if (wr_clr)
                wr_ptr <= '0;
            else if (wr_inc)
                wr_ptr <= wr_ptr + 1'b1;
        end
    end

endmodule
